// File: rtl/fusion_sequencer_pkg.sv
// rtl/fusion_sequencer_pkg.sv - shared types and helpers for the fusion sequencer
package fusion_pkg;

    typedef enum logic [1:0] {
        CFG_2B  = 2'b00,
        CFG_4B  = 2'b01,
        CFG_8B  = 2'b10,
        CFG_BAD = 2'b11
    } cfg_e;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

    // Field width selector for a lane accumulator: 16-bit, 32-bit or full ACC_W field
    localparam logic [1:0] FW_16  = 2'd0;
    localparam logic [1:0] FW_32  = 2'd1;
    localparam logic [1:0] FW_ACC = 2'd2;

    function automatic logic [2:0] lanes_for_cfg(input logic [1:0] cfga, input logic [1:0] cfgb);
        if (cfga == CFG_8B && cfgb == CFG_8B) return 3'd1;
        if ({cfga, cfgb} == 4'b1001 || {cfga, cfgb} == 4'b0110) return 3'd2;
        return 3'd4;
    endfunction

    function automatic logic cfg_is_bad(input logic [1:0] cfga, input logic [1:0] cfgb);
        return (cfga == CFG_BAD) || (cfgb == CFG_BAD);
    endfunction

endpackage

// File: rtl/fusion_sequencer_if.sv
// rtl/fusion_sequencer_if.sv - job, operand, fusion-unit and result signals of the sequencer
interface fusion_sequencer_if #(
    parameter int ACC_W = 32,
    parameter int LEN_W = 10
);
    logic                 job_valid;
    logic                 job_ready;
    logic [1:0]           job_cfga;
    logic [1:0]           job_cfgb;
    logic                 job_sa;
    logic                 job_sb;
    logic [LEN_W-1:0]     job_len;
    logic                 op_valid;
    logic                 op_ready;
    logic [7:0]           op_a;
    logic [7:0]           op_b;
    logic [7:0]           fu_a;
    logic [7:0]           fu_b;
    logic                 fu_sa;
    logic                 fu_sb;
    logic [1:0]           fu_cfga;
    logic [1:0]           fu_cfgb;
    logic [63:0]          fu_out;
    logic                 res_valid;
    logic                 res_ready;
    logic [4*ACC_W-1:0]   res_data;
    logic                 res_err;

    modport slave (
        input  job_valid, job_cfga, job_cfgb, job_sa, job_sb, job_len,
        input  op_valid, op_a, op_b, fu_out, res_ready,
        output job_ready, op_ready, fu_a, fu_b, fu_sa, fu_sb, fu_cfga, fu_cfgb,
        output res_valid, res_data, res_err
    );

    modport master (
        output job_valid, job_cfga, job_cfgb, job_sa, job_sb, job_len,
        output op_valid, op_a, op_b, fu_out, res_ready,
        input  job_ready, op_ready, fu_a, fu_b, fu_sa, fu_sb, fu_cfga, fu_cfgb,
        input  res_valid, res_data, res_err
    );
endinterface

// File: rtl/fusion_sequencer_lane_accumulator.sv
// rtl/fusion_sequencer_lane_accumulator.sv - one lane: extend a fusion-unit field and add it in
module lane_accumulator #(
    parameter int ACC_W = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_clr,
    input  logic                                   i_en,
    input  logic                                   i_signed,
    input  logic [1:0]                             i_fw,
    input  logic [((ACC_W > 32) ? ACC_W : 32)-1:0] i_field,
    output logic [ACC_W-1:0]                       o_acc
);
    import fusion_pkg::*;

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_ext;

    // Sign- or zero-extend the selected field width to the accumulator width
    always_comb begin
        w_ext = '0;
        if (i_fw == FW_16) begin
            if (i_signed) w_ext = ACC_W'($signed(i_field[15:0]));
            else          w_ext = ACC_W'(i_field[15:0]);
        end else if (i_fw == FW_32) begin
            if (i_signed) w_ext = ACC_W'($signed(i_field[31:0]));
            else          w_ext = ACC_W'(i_field[31:0]);
        end else begin
            w_ext = i_field[ACC_W-1:0];
        end
    end

    // Wrapping accumulate; clear wins so a new job always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_acc <= '0;
        else if (i_clr) r_acc <= '0;
        else if (i_en)  r_acc <= r_acc + w_ext;
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/fusion_sequencer.sv
// rtl/fusion_sequencer.sv - job-level controller feeding one fusion unit and accumulating its lanes
module fusion_sequencer #(
    parameter int FU_LATENCY = 1,
    parameter int ACC_W      = 32,
    parameter int LEN_W      = 10
) (
    input logic               clk,
    input logic               rst_n,
    fusion_sequencer_if.slave bus
);
    import fusion_pkg::*;

    localparam int FIELD_W = (ACC_W > 32) ? ACC_W : 32;
    localparam logic [1:0] ST_IDLE  = 2'(SEQ_IDLE);
    localparam logic [1:0] ST_RUN   = 2'(SEQ_RUN);
    localparam logic [1:0] ST_DRAIN = 2'(SEQ_DRAIN);
    localparam logic [1:0] ST_DONE  = 2'(SEQ_DONE);

    logic [1:0]            r_state;
    logic [1:0]            r_cfga;
    logic [1:0]            r_cfgb;
    logic                  r_sa;
    logic                  r_sb;
    logic                  r_err;
    logic [LEN_W-1:0]      r_rem;
    logic [FU_LATENCY-1:0] r_pipe;
    logic [FU_LATENCY-1:0] w_pipe_next;
    logic                  w_job_acc;
    logic                  w_bad;
    logic                  w_op_ready;
    logic                  w_issue;
    logic                  w_tail;
    logic                  w_signed;
    logic [2:0]            w_lanes;
    logic [1:0]            w_fw;
    logic [FIELD_W-1:0]    w_field [4];
    logic [3:0]            w_en;
    logic [ACC_W-1:0]      w_acc [4];

    assign w_job_acc  = bus.job_valid && (r_state == ST_IDLE);
    assign w_bad      = cfg_is_bad(bus.job_cfga, bus.job_cfgb);
    assign w_op_ready = (r_state == ST_RUN) && (r_rem != '0);
    assign w_issue    = bus.op_valid && w_op_ready;
    assign w_tail     = r_pipe[FU_LATENCY-1];
    assign w_signed   = r_sa | r_sb;
    assign w_lanes    = lanes_for_cfg(r_cfga, r_cfgb);
    assign w_fw       = (w_lanes == 3'd1) ? FW_ACC : (w_lanes == 3'd2) ? FW_32 : FW_16;

    // Next value of the in-flight shift register; DRAIN ends when it would become empty
    always_comb begin
        w_pipe_next    = '0;
        w_pipe_next[0] = w_issue;
        for (int i = 1; i < FU_LATENCY; i++) w_pipe_next[i] = r_pipe[i-1];
    end

    // In-flight beat tracking, one bit per fusion-unit pipeline stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pipe <= '0;
        else        r_pipe <= w_pipe_next;
    end

    // Job FSM plus the per-job latched configuration and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cfga  <= '0;
            r_cfgb  <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_err   <= 1'b0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.job_valid) begin
                    r_cfga  <= bus.job_cfga;
                    r_cfgb  <= bus.job_cfgb;
                    r_sa    <= bus.job_sa;
                    r_sb    <= bus.job_sb;
                    r_rem   <= bus.job_len;
                    r_err   <= w_bad;
                    r_state <= (w_bad || bus.job_len == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: if (w_issue) begin
                    r_rem <= r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) r_state <= ST_DRAIN;
                end
                ST_DRAIN: if (w_pipe_next == '0) r_state <= ST_DONE;
                default: if (bus.res_ready) begin
                    r_state <= ST_IDLE;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    // Slice fu_out into lane fields by precision mode and enable only the live lanes
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_field[i] = '0;
            w_en[i]    = w_tail && (i < int'(w_lanes));
            if (w_lanes == 3'd4)      w_field[i] = FIELD_W'(bus.fu_out >> (16 * i));
            else if (w_lanes == 3'd2) w_field[i] = FIELD_W'(bus.fu_out >> (32 * i));
            else                      w_field[i] = FIELD_W'(bus.fu_out);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        lane_accumulator #(.ACC_W(ACC_W)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_clr    (w_job_acc),
            .i_en     (w_en[g]),
            .i_signed (w_signed),
            .i_fw     (w_fw),
            .i_field  (w_field[g]),
            .o_acc    (w_acc[g])
        );
    end

    assign bus.job_ready = (r_state == ST_IDLE);
    assign bus.op_ready  = w_op_ready;
    assign bus.fu_a      = w_issue ? bus.op_a : 8'h00;
    assign bus.fu_b      = w_issue ? bus.op_b : 8'h00;
    assign bus.fu_sa     = r_sa;
    assign bus.fu_sb     = r_sb;
    assign bus.fu_cfga   = r_cfga;
    assign bus.fu_cfgb   = r_cfgb;
    assign bus.res_valid = (r_state == ST_DONE);
    assign bus.res_err   = r_err;
    assign bus.res_data  = {w_acc[3], w_acc[2], w_acc[1], w_acc[0]};

endmodule

// File: tb/tb_fusion_sequencer.sv
// tb/tb_fusion_sequencer.sv - directed vector bench for fusion_sequencer
module tb_fusion_sequencer;

    localparam int ACC_W      = 32;
    localparam int LEN_W      = 10;
    localparam int FU_LATENCY = 1;

    typedef struct packed {
        logic [1:0]       cfga;
        logic [1:0]       cfgb;
        logic             sa;
        logic             sb;
        logic [LEN_W-1:0] len;
        logic             model;
        logic [63:0]      stub;
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [127:0]     exp_data;
        logic             exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic use_model = 1'b0;
    logic [63:0] stub = '0;
    int total = 0;
    int bad = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    fusion_sequencer_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    fusion_sequencer #(.FU_LATENCY(FU_LATENCY), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stand-in fusion unit: registered 8x8 product (1 cycle) or a constant stub word
    logic signed [17:0] w_prod;
    always_comb w_prod = $signed({bus.fu_sa & bus.fu_a[7], bus.fu_a}) * $signed({bus.fu_sb & bus.fu_b[7], bus.fu_b});
    always @(posedge clk) bus.fu_out <= use_model ? {{46{w_prod[17]}}, w_prod} : stub;

    function automatic vec_t mk(input logic [1:0] ca, input logic [1:0] cb, input logic sa, input logic sb,
                                input int len, input logic model, input logic [63:0] st,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [127:0] d, input logic err);
        vec_t v;
        v.cfga = ca; v.cfgb = cb; v.sa = sa; v.sb = sb; v.len = LEN_W'(len);
        v.model = model; v.stub = st; v.a = a; v.b = b; v.exp_data = d; v.exp_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic start_job(input logic [1:0] ca, input logic [1:0] cb, input logic sa, input logic sb, input int len);
        @(negedge clk);
        chk("job_ready before job", bus.job_ready, 1'b1);
        bus.job_cfga = ca; bus.job_cfgb = cb; bus.job_sa = sa; bus.job_sb = sb;
        bus.job_len = LEN_W'(len); bus.job_valid = 1'b1;
        @(negedge clk);
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_res(input string name);
        int n = 0;
        while (!bus.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, bus.res_valid, 1'b1);
    endtask

    task automatic finish_res();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("job_ready after result", bus.job_ready, 1'b1);
    endtask

    task automatic run_vec(input int k);
        vec_t v = vecs[k];
        use_model = v.model;
        stub = v.stub;
        start_job(v.cfga, v.cfgb, v.sa, v.sb, int'(v.len));
        if (!v.exp_err) begin
            for (int i = 0; i < int'(v.len); i++) begin
                bus.op_valid = 1'b1; bus.op_a = v.a[i]; bus.op_b = v.b[i];
                #1;
                chk($sformatf("v%0d op_ready", k), bus.op_ready, 1'b1);
                chk($sformatf("v%0d fu_cfg", k), {bus.fu_cfga, bus.fu_cfgb}, {v.cfga, v.cfgb});
                @(negedge clk);
            end
        end
        bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
        wait_res($sformatf("v%0d res_valid", k));
        chk($sformatf("v%0d res_data", k), bus.res_data, v.exp_data);
        chk($sformatf("v%0d res_err", k), bus.res_err, v.exp_err);
        finish_res();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [127:0] held;
        bus.job_valid = 0; bus.job_cfga = 0; bus.job_cfgb = 0; bus.job_sa = 0; bus.job_sb = 0;
        bus.job_len = 0; bus.op_valid = 0; bus.op_a = 0; bus.op_b = 0; bus.res_ready = 0;

        vecs[0] = mk(2'b10, 2'b10, 1, 1, 3, 1, 64'h0, 32'h007F_FE03, 32'h00FF_0504, 128'hFFFFFF83, 0);
        vecs[1] = mk(2'b01, 2'b01, 0, 0, 2, 0, 64'h0001_0002_0003_0004, 0, 0, {32'd2, 32'd4, 32'd6, 32'd8}, 0);
        vecs[2] = mk(2'b10, 2'b01, 1, 0, 4, 0, 64'hFFFF_FFFF_0000_0005, 0, 0, {64'h0, 32'hFFFFFFFC, 32'd20}, 0);
        vecs[3] = mk(2'b11, 2'b10, 0, 0, 3, 0, 64'h1234_5678_9ABC_DEF0, 0, 0, 128'h0, 1);
        vecs[4] = mk(2'b10, 2'b10, 0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 0, 0, 128'h0, 0);
        vecs[5] = mk(2'b00, 2'b00, 0, 1, 1, 0, 64'h8000_FFFF_7FFF_0001, 0, 0,
                     {32'hFFFF8000, 32'hFFFFFFFF, 32'h00007FFF, 32'h00000001}, 0);
        vecs[6] = mk(2'b00, 2'b01, 0, 0, 1, 0, 64'h8000_FFFF_7FFF_0001, 0, 0,
                     {32'h00008000, 32'h0000FFFF, 32'h00007FFF, 32'h00000001}, 0);
        vecs[7] = mk(2'b10, 2'b10, 0, 0, 3, 0, 64'hDEAD_BEEF_8000_0000, 0, 0, 128'h80000000, 0);
        vecs[8] = mk(2'b01, 2'b10, 0, 0, 2, 0, 64'h0000_0003_8000_0001, 0, 0, {64'h0, 32'd6, 32'd2}, 0);
        vecs[9] = mk(2'b01, 2'b11, 1, 1, 2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 128'h0, 1);

        // Reset state
        @(negedge clk);
        chk("reset job_ready", bus.job_ready, 1'b1);
        chk("reset res_valid", bus.res_valid, 1'b0);
        chk("reset outputs", {bus.op_ready, bus.fu_a, bus.fu_b, bus.fu_sa, bus.fu_sb,
                              bus.fu_cfga, bus.fu_cfgb, bus.res_err}, '0);
        chk("reset res_data", bus.res_data, 128'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) run_vec(k);

        // Result latency after the last beat
        use_model = 1'b0; stub = 64'h0001_0002_0003_0004;
        start_job(2'b01, 2'b01, 0, 0, 2);
        bus.op_valid = 1'b1; bus.op_a = 8'h11; bus.op_b = 8'h22;
        @(negedge clk);
        n = 0;
        do begin
            @(negedge clk);
            bus.op_valid = 1'b0;
            n++;
        end while (!bus.res_valid && n < 20);
        chk("result latency", n, FU_LATENCY + 1);
        chk("latency res_data", bus.res_data, {32'd2, 32'd4, 32'd6, 32'd8});
        finish_res();

        // Illegal cfg: straight to DONE, no operand accepted
        bus.op_valid = 1'b1;
        start_job(2'b11, 2'b11, 1, 1, 4);
        chk("bad cfg op_ready", bus.op_ready, 1'b0);
        chk("bad cfg res_valid next cycle", bus.res_valid, 1'b1);
        chk("bad cfg res_err", bus.res_err, 1'b1);
        chk("bad cfg res_data", bus.res_data, 128'h0);
        bus.op_valid = 1'b0;
        finish_res();

        // Gapped operands then a stalled result
        use_model = 1'b1;
        start_job(2'b10, 2'b10, 0, 0, 2);
        bus.op_valid = 1'b1; bus.op_a = 8'd10; bus.op_b = 8'd3;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op_a = 8'h55; bus.op_b = 8'h55;
        #1;
        chk("gap fu_a zero", {bus.fu_a, bus.fu_b}, 16'h0);
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_a = 8'd20; bus.op_b = 8'd4;
        @(negedge clk);
        bus.op_valid = 1'b0;
        wait_res("gap res_valid");
        chk("gap res_data", bus.res_data, 128'd110);
        held = bus.res_data;
        bus.job_valid = 1'b1; bus.job_len = 10'd1; bus.job_cfga = 2'b00; bus.job_cfgb = 2'b00;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk($sformatf("stall%0d res_data", s), bus.res_data, held);
            chk($sformatf("stall%0d job_ready/res_valid", s), {bus.job_ready, bus.res_valid}, 2'b01);
        end
        bus.job_valid = 1'b0;
        finish_res();

        // Reset in the middle of a job
        start_job(2'b10, 2'b10, 0, 0, 5);
        bus.op_valid = 1'b1; bus.op_a = 8'd1; bus.op_b = 8'd1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst res_data", bus.res_data, 128'h0);
        chk("midrst fu_a/op_ready", {bus.fu_a, bus.fu_b, bus.op_ready}, 17'h0);
        chk("midrst res_valid/job_ready", {bus.res_valid, bus.job_ready}, 2'b01);
        chk("midrst fu cfg", {bus.fu_cfga, bus.fu_cfgb, bus.fu_sa, bus.fu_sb, bus.res_err}, 7'h0);
        @(negedge clk);
        bus.op_valid = 1'b0;
        rst_n = 1'b1;
        start_job(2'b10, 2'b10, 0, 0, 1);
        bus.op_valid = 1'b1; bus.op_a = 8'd1; bus.op_b = 8'd1;
        @(negedge clk);
        bus.op_valid = 1'b0;
        wait_res("post-reset res_valid");
        chk("post-reset res_data", bus.res_data, 128'd1);
        finish_res();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
